// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I fetch stage.
//   NOP_INSTR_DEF / RESET_PC_DEF : default bubble encoding and reset PC
//   fetch_state_e                : instruction-fetch request FSM states
package riscv_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction/PC buffer that catches a fetch response arriving
// while the IF/ID register is stalled.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   wr, wr_instr/pc   : capture an entry
//   rd                : entry consumed by IF/ID
//   clr               : discard entry (redirect)
//   full, instr, pc   : buffer state and contents
module fetch_skid #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic            clr,
    input  logic [31:0]     wr_instr,
    input  logic [XLEN-1:0] wr_pc,
    output logic            full,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);

    logic            full_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;

    // Occupancy flag and stored entry; clear/read take priority over write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            full_r  <= 1'b0;
            instr_r <= 32'h0000_0000;
            pc_r    <= {XLEN{1'b0}};
        end else begin
            if (clr || rd) begin
                full_r <= 1'b0;
            end else if (wr) begin
                full_r <= 1'b1;
            end else begin
                full_r <= full_r;
            end
            if (wr) begin
                instr_r <= wr_instr;
                pc_r    <= wr_pc;
            end else begin
                instr_r <= instr_r;
                pc_r    <= pc_r;
            end
        end
    end

    assign full  = full_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_stage_sva.sv
// Protocol checker for fetch_stage: a live response must never find the
// skid buffer occupied, otherwise an instruction would be lost.
//   clock, reset : clock and synchronous active-low reset
//   rsp_live     : response accepted as a real instruction this cycle
//   skid_full    : skid buffer occupied
module fetch_stage_sva (
    input logic clock,
    input logic reset,
    input logic rsp_live,
    input logic skid_full
);

    // Skid overflow would silently drop an instruction.
    a_no_skid_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(rsp_live && skid_full));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of the RV32I core.
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   StallF/StallD/FlushD : hazard-unit controls
//   PCSrcE/PCTargetE     : redirect from execute
//   imem_req_*           : fetch request channel (valid/ready, word address)
//   imem_rsp_*           : fetch response channel (one per accepted request)
//   InstrD/PCD/PCPlus4D/ValidD : IF/ID register contents for decode
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

    fetch_state_e    state_r, state_s;
    logic [XLEN-1:0] pcf_r, req_pc_r;
    logic            kill_r, kill_s;
    logic [31:0]     instr_d_r;
    logic [XLEN-1:0] pc_d_r, pcplus4_d_r;
    logic            valid_d_r;

    logic            req_valid_s, issue_s, issue_ok_s, rsp_live_s;
    logic [XLEN-1:0] req_addr_s;
    logic            skid_wr_s, skid_rd_s, skid_full_s;
    logic [31:0]     skid_instr_s;
    logic [XLEN-1:0] skid_pc_s;

    // A response arriving in the redirect cycle is wrong-path, so it is
    // discarded just like a killed one.
    assign rsp_live_s = (state_r == S_WAIT) && imem_rsp_valid && !kill_r && !PCSrcE;
    assign skid_wr_s  = rsp_live_s && StallD && !FlushD;
    assign skid_rd_s  = !FlushD && !StallD && skid_full_s;
    // Issue is also held off while the skid is being filled, so the one
    // outstanding request can never land on an occupied skid.
    assign issue_ok_s = !StallF && !PCSrcE && !skid_full_s && !skid_wr_s;

    // Request FSM: next state, request valid and address.
    always_comb begin
        state_s     = state_r;
        req_valid_s = 1'b0;
        req_addr_s  = pcf_r;
        case (state_r)
            S_IDLE: begin
                req_valid_s = issue_ok_s;
                if (issue_ok_s) begin
                    state_s = imem_req_ready ? S_WAIT : S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                // Address comes from req_pc_r: a redirect may rewrite PCF
                // while this request is still pending.
                req_valid_s = 1'b1;
                req_addr_s  = req_pc_r;
                if (imem_req_ready) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    req_valid_s = issue_ok_s;
                    if (issue_ok_s) begin
                        state_s = imem_req_ready ? S_WAIT : S_REQ;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // A new fetch attempt (not a held request) advances PCF.
    assign issue_s = req_valid_s && (state_r != S_REQ);

    // Kill marks the single outstanding request as wrong-path.
    always_comb begin
        kill_s = kill_r;
        if (PCSrcE) begin
            kill_s = (state_s != S_IDLE);
        end else if ((state_r == S_WAIT) && imem_rsp_valid) begin
            kill_s = 1'b0;
        end else begin
            kill_s = kill_r;
        end
    end

    // PC, FSM and IF/ID pipeline registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            pcf_r       <= RESET_PC;
            req_pc_r    <= RESET_PC;
            kill_r      <= 1'b0;
            instr_d_r   <= NOP_INSTR;
            pc_d_r      <= {XLEN{1'b0}};
            pcplus4_d_r <= PC_STEP;
            valid_d_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            kill_r  <= kill_s;

            if (PCSrcE) begin
                pcf_r <= PCTargetE & ALIGN_MASK;
            end else if (issue_s) begin
                pcf_r <= pcf_r + PC_STEP;
            end else begin
                pcf_r <= pcf_r;
            end

            if (issue_s) begin
                req_pc_r <= pcf_r;
            end else begin
                req_pc_r <= req_pc_r;
            end

            if (FlushD) begin
                instr_d_r <= NOP_INSTR;
                valid_d_r <= 1'b0;
            end else if (StallD) begin
                instr_d_r <= instr_d_r;
                valid_d_r <= valid_d_r;
            end else if (skid_full_s) begin
                instr_d_r   <= skid_instr_s;
                pc_d_r      <= skid_pc_s;
                pcplus4_d_r <= skid_pc_s + PC_STEP;
                valid_d_r   <= 1'b1;
            end else if (rsp_live_s) begin
                instr_d_r   <= imem_rsp_data;
                pc_d_r      <= req_pc_r;
                pcplus4_d_r <= req_pc_r + PC_STEP;
                valid_d_r   <= 1'b1;
            end else begin
                instr_d_r <= NOP_INSTR;
                valid_d_r <= 1'b0;
            end
        end
    end

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clock    (clock),
        .reset    (reset),
        .wr       (skid_wr_s),
        .rd       (skid_rd_s),
        .clr      (PCSrcE),
        .wr_instr (imem_rsp_data),
        .wr_pc    (req_pc_r),
        .full     (skid_full_s),
        .instr    (skid_instr_s),
        .pc       (skid_pc_s)
    );

    fetch_stage_sva u_sva (
        .clock     (clock),
        .reset     (reset),
        .rsp_live  (rsp_live_s),
        .skid_full (skid_full_s)
    );

    assign imem_req_valid = req_valid_s && reset;
    assign imem_req_addr  = req_addr_s;
    assign InstrD         = instr_d_r;
    assign PCD            = pc_d_r;
    assign PCPlus4D       = pcplus4_d_r;
    assign ValidD         = valid_d_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: imem model with random latency plus
// an in-order program scoreboard (each delivered instruction must be the
// next sequential PC, restarting at the redirect target).
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int n_tests = 0;
    int n_fail  = 0;

    // imem model: single pending request with countdown
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          lat_min = 1, lat_max = 1;
    logic [31:0] hs_log[$];

    // scoreboard / protocol state
    logic [31:0] exp_pc = 32'h0;
    int          delivered = 0;
    logic        hold_req = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    fetch_stage dut (
        .clock(clock), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    // One clock cycle: present imem response, check protocol, advance models.
    task automatic drive_cycle();
        logic        presented, hs, c_reset, c_stall, c_flush, c_redirect, pre_valid;
        logic [31:0] hs_addr, c_target, pre_instr, pre_pc, pre_p4;
        presented      = pend && (pend_cnt == 0);
        imem_rsp_valid = presented;
        imem_rsp_data  = presented ? mem_word(pend_addr) : 32'h0;
        #3;
        hs         = imem_req_valid && imem_req_ready;
        hs_addr    = imem_req_addr;
        c_reset    = reset;
        c_stall    = StallD;
        c_flush    = FlushD;
        c_redirect = PCSrcE;
        c_target   = PCTargetE;
        pre_instr  = InstrD;
        pre_pc     = PCD;
        pre_p4     = PCPlus4D;
        pre_valid  = ValidD;
        if (!c_reset) begin
            n_tests++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL req_valid_in_reset: got %b expected 0", imem_req_valid);
            end
        end else begin
            if (hold_req) begin
                n_tests++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== hold_addr) begin
                    n_fail++;
                    $display("FAIL req_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                             imem_req_valid, imem_req_addr, hold_addr);
                end
            end
            if (hs) begin
                n_tests++;
                if ((pend && !presented) || hs_addr[1:0] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL req_legal: got addr=%h pending=%b expected aligned, none pending",
                             hs_addr, pend && !presented);
                end
            end
        end
        hold_req  = c_reset && imem_req_valid && !imem_req_ready;
        hold_addr = imem_req_addr;
        @(posedge clock);
        #1;
        if (!c_reset) begin
            pend     = 1'b0;
            exp_pc   = 32'h0;
            hold_req = 1'b0;
        end else begin
            if (presented) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = hs_addr;
                pend_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
                hs_log.push_back(hs_addr);
            end
            n_tests++;
            if (c_flush) begin
                if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== pre_pc) begin
                    n_fail++;
                    $display("FAIL flush_bubble: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=%h",
                             ValidD, InstrD, PCD, NOP, pre_pc);
                end
            end else if (c_stall) begin
                if (ValidD !== pre_valid || InstrD !== pre_instr || PCD !== pre_pc || PCPlus4D !== pre_p4) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b instr=%h pc=%h expected v=%b instr=%h pc=%h",
                             ValidD, InstrD, PCD, pre_valid, pre_instr, pre_pc);
                end
            end else if (ValidD === 1'b1) begin
                if (PCD !== exp_pc || InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL in_order: got pc=%h instr=%h p4=%h expected pc=%h instr=%h p4=%h",
                             PCD, InstrD, PCPlus4D, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== pre_pc) begin
                    n_fail++;
                    $display("FAIL bubble: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=%h",
                             ValidD, InstrD, PCD, NOP, pre_pc);
                end
            end
            if (c_redirect) exp_pc = c_target & 32'hFFFF_FFFC;
        end
    endtask

    task automatic clear_ctrl();
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; imem_req_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_ctrl();
        lat_min = 1; lat_max = 1;
        reset = 1'b0;
        drive_cycle();
        drive_cycle();
        reset = 1'b1;
        hs_log.delete();
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got instr=%h pc=%h p4=%h v=%b expected %h 0 4 0",
                     name, InstrD, PCD, PCPlus4D, ValidD, NOP);
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = tgt;
        drive_cycle();
        PCSrcE = 1'b0; FlushD = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset_values");
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle();
            if (i >= 2) begin
                n_tests++;
                if (ValidD !== 1'b1 || PCD !== 32'((i - 2) * 4)) begin
                    n_fail++;
                    $display("FAIL stream_rate: got v=%b pc=%h expected v=1 pc=%h", ValidD, PCD, 32'((i - 2) * 4));
                end
            end
        end
    endtask

    task automatic test_skid();
        bit got12 = 1'b0;
        do_reset();
        drive_cycle(); drive_cycle(); drive_cycle();   // PCD=4, response for 8 next
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            n_tests++;
            if (PCD !== 32'h4 || ValidD !== 1'b1) begin
                n_fail++;
                $display("FAIL skid_frozen: got pc=%h v=%b expected pc=4 v=1", PCD, ValidD);
            end
        end
        StallD = 1'b0;
        drive_cycle();
        n_tests++;
        if (PCD !== 32'h8 || ValidD !== 1'b1 || InstrD !== mem_word(32'h8)) begin
            n_fail++;
            $display("FAIL skid_release: got pc=%h v=%b expected pc=8 v=1", PCD, ValidD);
        end
        for (int i = 0; i < 6 && !got12; i++) begin
            drive_cycle();
            if (ValidD === 1'b1) got12 = 1'b1;
        end
        n_tests++;
        if (!got12 || PCD !== 32'hC) begin
            n_fail++;
            $display("FAIL skid_next: got pc=%h seen=%b expected pc=c seen=1", PCD, got12);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        bit seen = 1'b0;
        int idx;
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 80 && !found; i++) begin
            drive_cycle();
            if (hs_log.size() > 0 && hs_log[$] == 32'h20 && pend) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL redir_reach_20: got no request for 20 expected one");
        end
        idx = hs_log.size();
        redirect(32'h100);
        for (int i = 0; i < 20 && !seen; i++) begin
            drive_cycle();
            if (ValidD === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || PCD !== 32'h100 || hs_log.size() <= idx || hs_log[idx] !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_wait: got pc=%h seen=%b expected pc=100 and next req=100", PCD, seen);
        end
    endtask

    task automatic test_ready_low();
        bit seen = 1'b0;
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) redirect(32'h200);
            else drive_cycle();
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL ready_low_hold: got v=%b addr=%h expected v=1 addr=0", imem_req_valid, imem_req_addr);
            end
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_cycle();
            if (ValidD === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || PCD !== 32'h200 || hs_log.size() < 2 || hs_log[0] !== 32'h0 || hs_log[1] !== 32'h200) begin
            n_fail++;
            $display("FAIL ready_low_kill: got pc=%h nreq=%0d expected pc=200 reqs 0,200", PCD, hs_log.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_cycle(); drive_cycle();                 // PCD=0, response for 4 next
        FlushD = 1'b1; StallD = 1'b1;
        drive_cycle();
        FlushD = 1'b0; StallD = 1'b0;
        exp_pc = exp_pc + 32'd4;                      // PC 4 was dropped
        n_tests++;
        if (InstrD !== NOP || ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rsp: got instr=%h v=%b expected %h 0", InstrD, ValidD, NOP);
        end
        drive_cycle();
        n_tests++;
        if (ValidD !== 1'b1 || PCD !== 32'h8) begin
            n_fail++;
            $display("FAIL flush_skid_empty: got pc=%h v=%b expected pc=8 v=1", PCD, ValidD);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect(32'hFFFF_FFFB);
        for (int i = 0; i < 8; i++) drive_cycle();
        n_tests++;
        if (hs_log.size() < 3 || hs_log[0] !== 32'hFFFF_FFF8 || hs_log[1] !== 32'hFFFF_FFFC || hs_log[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap: got %0d reqs first=%h expected fffffff8,fffffffc,0",
                     hs_log.size(), (hs_log.size() > 0) ? hs_log[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 5 && !pend; i++) drive_cycle();
        reset = 1'b0;
        drive_cycle();
        check_reset_values("reset_mid_wait");
        reset = 1'b1;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_cycle();
            if (ValidD === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || PCD !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got pc=%h seen=%b expected pc=0", PCD, seen);
        end
    endtask

    task automatic test_random();
        int start;
        do_reset();
        lat_min = 1; lat_max = 3;
        start = delivered;
        for (int i = 0; i < 1500; i++) begin
            StallF         = ($urandom_range(0, 9) == 0);
            StallD         = ($urandom_range(0, 5) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            PCSrcE         = ($urandom_range(0, 24) == 0);
            FlushD         = PCSrcE;
            PCTargetE      = $urandom();
            drive_cycle();
        end
        clear_ctrl();
        for (int i = 0; i < 10; i++) drive_cycle();
        n_tests++;
        if (delivered - start < 150) begin
            n_fail++;
            $display("FAIL random_progress: got %0d deliveries expected at least 150", delivered - start);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_redirect_wait();
        test_ready_low();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
